// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   RESET_PC_DEFAULT    - default program counter after reset
//   IMEM_BASE_DEFAULT   - default lowest legal fetch address
//   IMEM_WORDS_DEFAULT  - default fetch window size in 32-bit words
//   NOP_INSTR           - canonical RV32I NOP (addi x0, x0, 0)
//   fetch_state_t       - fetch FSM state encoding (RUN / HALT)
//   is_aligned()        - word-alignment test for a byte address
//   in_window()         - range test of an address against a word window
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0100_0000;
    localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0100_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Evaluated in 34 bits so that base + 4*words cannot wrap past 2^32
    // and make a window at the top of the address map look empty.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        logic [33:0] lo;
        logic [33:0] hi;
        logic [33:0] a;
        lo = {2'b00, base};
        hi = lo + ({2'b00, words} << 2);
        a  = {2'b00, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
//   id_ready       - decode accepts the IF/ID register this cycle
//   redirect_valid - replace the PC with redirect_pc
//   redirect_pc    - redirect target
//   imem_instr     - combinational read data returned by imem
//   imem_addr      - fetch address (always the registered PC)
//   if_valid       - IF/ID register holds a live instruction
//   if_pc          - PC of the registered instruction
//   if_instr       - registered instruction
//   fetch_fault    - sticky fault flag
//   fetch_count    - number of instructions issued to decode
// Modports:
//   master - the fetch unit
//   slave  - the surrounding pipeline / memory / bench
//
// Handshake: a word moves from IF/ID into decode on a rising edge where
// if_valid=1 and id_ready=1. if_valid does not depend on id_ready, and a
// held word stays unchanged until it is accepted or flushed by a redirect.
// ----------------------------------------------------------------------------
interface fetch_unit_if;

    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    modport master (
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_instr,
        output imem_addr,
        output if_valid,
        output if_pc,
        output if_instr,
        output fetch_fault,
        output fetch_count
    );

    modport slave (
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        output imem_instr,
        input  imem_addr,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        input  fetch_fault,
        input  fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load, hold and flush controls.
//   clk        in  - rising-edge clock
//   rst        in  - asynchronous active-low reset
//   load       in  - capture next_pc / next_instr and mark the entry valid
//   flush      in  - invalidate the entry (wins over load)
//   next_pc    in  - PC of the word being captured
//   next_instr in  - word being captured
//   valid      out - entry holds a live instruction
//   pc         out - PC of the held instruction
//   instr      out - held instruction
// With neither load nor flush the entry holds unchanged.
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= 32'h0000_0000;
            instr <= NOP_INSTR;
        end else if (flush) begin
            // Only the valid bit drops; pc/instr keep their last value so a
            // flushed slot still shows what was there for debug.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= next_pc;
            instr <= next_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the RV32I core. Owns the program counter,
// drives the instruction memory address and captures the returned word into
// the IF/ID register. Supports a downstream stall, a redirect path and a
// sticky fault on a misaligned redirect target.
//
// Parameters:
//   RESET_PC   - PC loaded on reset
//   IMEM_BASE  - lowest legal fetch address (range check only)
//   IMEM_WORDS - legal fetch window size in words (range check only)
// Ports:
//   clk   in  - rising-edge clock
//   rst   in  - asynchronous active-low reset
//   bus   if  - fetch_unit_if.master (control, imem and IF/ID signals)
//   state out - current FSM state, for debug and checkers
//
// Build option: define FETCH_BOUNDS_CHECK_EN to halt with a fault when an
// advancing edge would fetch from outside [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS).
// Without it, misalignment is the only fault source.
//
// Per-edge priority in RUN: aligned redirect, misaligned redirect, stall,
// advance. HALT holds everything and is left only through reset.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output fetch_state_t  state
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  count_q;
    logic [31:0]  count_d;
    logic         fault_q;
    logic         fault_d;
    logic         reg_load;
    logic         reg_flush;
    logic         pc_in_window;
    logic         bounds_fault;

    assign pc_in_window = in_window(pc_q, IMEM_BASE, IMEM_WORDS);

`ifdef FETCH_BOUNDS_CHECK_EN
    assign bounds_fault = !pc_in_window;
`else
    logic unused_window;
    assign bounds_fault  = 1'b0;
    assign unused_window = pc_in_window;
`endif

    // ------------------------------------------------------------------
    // State, PC, counter and fault registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and IF/ID control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        fault_d   = fault_q;
        reg_load  = 1'b0;
        reg_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    // A redirect wins over a stall. The slot is flushed;
                    // if decode took it this same edge it was already
                    // consumed, otherwise it was on the wrong path.
                    reg_flush = 1'b1;
                    if (is_aligned(bus.redirect_pc)) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (bus.id_ready) begin
                    if (bounds_fault) begin
                        state_d   = HALT;
                        fault_d   = 1'b1;
                        reg_flush = 1'b1;
                    end else begin
                        reg_load = 1'b1;
                        pc_d     = pc_q + 32'd4;    // wraps modulo 2^32
                        count_d  = count_q + 32'd1;
                    end
                end
            end
            HALT: begin
                // Keep the slot invalid; every other register holds.
                reg_flush = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (reg_load),
        .flush      (reg_flush),
        .next_pc    (pc_q),
        .next_instr (bus.imem_instr),
        .valid      (bus.if_valid),
        .pc         (bus.if_pc),
        .instr      (bus.if_instr)
    );

    // imem_addr comes straight from the PC register: no input reaches it
    // combinationally.
    assign bus.imem_addr   = pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = count_q;
    assign state           = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small imem model answers the fetch
// address combinationally. Each advancing edge pushes the expected
// {pc, instr} pair; a monitor pops and compares whenever decode accepts the
// IF/ID register (if_valid && id_ready at the edge). Register-level values
// (PC, counter, fault, state) are checked directly after each edge.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic         clk;
    logic         rst;
    fetch_state_t state;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0100_0000),
        .IMEM_BASE  (32'h0100_0000),
        .IMEM_WORDS (1024)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    // ------------------------------------------------------------------
    // Clock / watchdog
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // imem model: four program words at BASE, elsewhere the inverted address
    // ------------------------------------------------------------------
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && a < BASE + 32'd16) begin
            case (off[3:2])
                2'd0:    return 32'h0010_0093;
                2'd1:    return 32'h0020_0113;
                2'd2:    return 32'h0020_80b3;
                default: return 32'hffdf_f06f;
            endcase
        end
        return ~a;
    endfunction

    assign bus.imem_instr = imem_word(bus.imem_addr);

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Monitor: an accepted transfer is if_valid && id_ready seen mid-cycle.
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (rst && bus.if_valid && bus.id_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected: got pc %08h instr %08h, required no transfer",
                             bus.if_pc, bus.if_instr);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.if_pc, bus.if_instr} !== exp) begin
                        errors++;
                        $display("FAIL accept: got pc %08h instr %08h required pc %08h instr %08h",
                                 bus.if_pc, bus.if_instr, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Expect the word at the model PC to be captured on the coming edge.
    task automatic issue();
        exp_q.push_back({m_pc, imem_word(m_pc)});
        m_pc = m_pc + 32'd4;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_addr"},   bus.imem_addr,   32'h0100_0000);
        check({tag, "_if_valid"},    32'(bus.if_valid), 32'd0);
        check({tag, "_if_pc"},       bus.if_pc,       32'h0000_0000);
        check({tag, "_if_instr"},    bus.if_instr,    32'h0000_0013);
        check({tag, "_fetch_fault"}, 32'(bus.fetch_fault), 32'd0);
        check({tag, "_fetch_count"}, bus.fetch_count, 32'd0);
        check({tag, "_state"},       32'(state),      32'(RUN));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst  = 1'b0;
        m_pc = BASE;
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Two sequential fetches
        for (int i = 0; i < 2; i++) begin
            issue();
            drive(1'b1, 1'b0, 32'h0);
            cycle();
        end
        check("seq_if_valid", 32'(bus.if_valid), 32'd1);
        check("seq_if_pc",    bus.if_pc,       32'h0100_0004);
        check("seq_count2",   bus.fetch_count, 32'd2);

        // Stall for three cycles
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_if_instr",  bus.if_instr,    32'h0020_0113);
            check("stall_imem_addr", bus.imem_addr,   32'h0100_0008);
            check("stall_count",     bus.fetch_count, 32'd2);
            check("stall_if_valid",  32'(bus.if_valid), 32'd1);
        end

        // Two more fetches
        for (int i = 0; i < 2; i++) begin
            issue();
            drive(1'b1, 1'b0, 32'h0);
            cycle();
        end
        check("seq_if_pc4",    bus.if_pc,       32'h0100_000C);
        check("seq_if_instr4", bus.if_instr,    32'hffdf_f06f);
        check("seq_count4",    bus.fetch_count, 32'd4);

        // Redirect while stalled: held word is flushed, not accepted
        drive(1'b0, 1'b1, 32'h0100_0008);
        cycle();
        void'(exp_q.pop_back());
        m_pc = 32'h0100_0008;
        check("redir_bubble",    32'(bus.if_valid), 32'd0);
        check("redir_imem_addr", bus.imem_addr,   32'h0100_0008);
        check("redir_count",     bus.fetch_count, 32'd4);

        issue();
        drive(1'b1, 1'b0, 32'h0);
        cycle();
        check("redir_if_valid", 32'(bus.if_valid), 32'd1);
        check("redir_if_instr", bus.if_instr,    32'h0020_80b3);
        check("redir_if_pc",    bus.if_pc,       32'h0100_0008);

        // Misaligned redirect (decode accepts the live word the same edge)
        drive(1'b1, 1'b1, 32'h0100_0006);
        cycle();
        check("mis_fault",     32'(bus.fetch_fault), 32'd1);
        check("mis_if_valid",  32'(bus.if_valid), 32'd0);
        check("mis_imem_addr", bus.imem_addr,   32'h0100_000C);
        check("mis_state",     32'(state),      32'(HALT));
        check("mis_count",     bus.fetch_count, 32'd5);

        // HALT ignores redirects and id_ready
        drive(1'b1, 1'b1, 32'h0100_0000);
        cycle();
        cycle();
        check("halt_fault",     32'(bus.fetch_fault), 32'd1);
        check("halt_if_valid",  32'(bus.if_valid), 32'd0);
        check("halt_imem_addr", bus.imem_addr,   32'h0100_000C);
        check("halt_count",     bus.fetch_count, 32'd5);
        check("halt_state",     32'(state),      32'(HALT));

        // Asynchronous reset away from the clock edge
        drive(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        cycle();
        rst  = 1'b1;
        m_pc = BASE;

`ifndef FETCH_BOUNDS_CHECK_EN
        // Wrap-around of the PC past the top of the address map
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle();
        m_pc = 32'hFFFF_FFFC;
        check("wrap_imem_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_if_valid0",  32'(bus.if_valid), 32'd0);

        issue();
        drive(1'b1, 1'b0, 32'h0);
        cycle();
        check("wrap_imem_addr",  bus.imem_addr,   32'h0000_0000);
        check("wrap_fault",      32'(bus.fetch_fault), 32'd0);
        check("wrap_if_instr",   bus.if_instr,    32'h0000_0003);
        check("wrap_count",      bus.fetch_count, 32'd1);

        issue();
        cycle();
        check("wrap_imem_addr2", bus.imem_addr,   32'h0000_0004);
        check("wrap_count2",     bus.fetch_count, 32'd2);

        // Redirect with id_ready=1: the live word is accepted, then flushed
        drive(1'b1, 1'b1, BASE);
        cycle();
        check("wrap_exit_if_valid", 32'(bus.if_valid), 32'd0);
        check("wrap_exit_addr",     bus.imem_addr,   BASE);
`else
        // Out-of-range target is accepted; the fault fires on the next advance
        drive(1'b0, 1'b1, 32'h0000_1000);
        cycle();
        check("bounds_imem_addr0", bus.imem_addr, 32'h0000_1000);
        check("bounds_fault0",     32'(bus.fetch_fault), 32'd0);
        check("bounds_if_valid0",  32'(bus.if_valid), 32'd0);

        drive(1'b1, 1'b0, 32'h0);
        cycle();
        check("bounds_fault",     32'(bus.fetch_fault), 32'd1);
        check("bounds_state",     32'(state),      32'(HALT));
        check("bounds_if_valid",  32'(bus.if_valid), 32'd0);
        check("bounds_imem_addr", bus.imem_addr,   32'h0000_1000);
        check("bounds_count",     bus.fetch_count, 32'd0);
`endif

        drive(1'b0, 1'b0, 32'h0);
        cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. Owns the program counter, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register. Supports a downstream-ready stall, a redirect path for jumps and branches, and a sticky fault on a misaligned target. Sits directly upstream of `imem`: its `imem_addr` drives `imem.addr`, and `imem.instr_out` returns combinationally on `imem_instr`.

## Interface
- `RESET_PC`, default 32'h0100_0000: PC value loaded on reset.
- `IMEM_BASE`, default 32'h0100_0000: lowest legal fetch address (bounds check only).
- `IMEM_WORDS`, default 1024: legal fetch window size in 32-bit words (bounds check only).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_ready` in 1: decode accepts the IF/ID register this cycle.
- `redirect_valid` in 1: replace the PC with `redirect_pc`.
- `redirect_pc` in 32: redirect target.
- `imem_instr` in 32: combinational read data from `imem`.
- `imem_addr` out 32: always equals `pc_q`.
- `if_valid` out 1: IF/ID register holds a live instruction.
- `if_pc` out 32: PC of the registered instruction.
- `if_instr` out 32: registered instruction.
- `fetch_fault` out 1: sticky fault flag.
- `fetch_count` out 32: count of instructions issued to decode.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values:
  - `pc_q` = RESET_PC
  - `if_valid` = 0
  - `if_pc` = 0
  - `if_instr` = 32'h0000_0013 (NOP)
  - `fetch_fault` = 0
  - `fetch_count` = 0
- Each edge in RUN is evaluated in this priority order:
  1. **Redirect, aligned** (`redirect_valid`=1, `redirect_pc[1:0]`=0): `pc_q` ← `redirect_pc`; `if_valid` ← 0 (flush). Takes effect regardless of `id_ready`.
  2. **Redirect, misaligned** (`redirect_valid`=1, `redirect_pc[1:0]`≠0): go to HALT; `fetch_fault` ← 1; `if_valid` ← 0; `pc_q` holds.
  3. **Stall** (`id_ready`=0, no redirect): `pc_q`, `if_*` and `fetch_count` all hold.
  4. **Advance** (`id_ready`=1):
     - `if_instr` ← `imem_instr`; `if_pc` ← `pc_q`; `if_valid` ← 1.
     - `pc_q` ← `pc_q` + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
     - `fetch_count` ← `fetch_count` + 1, wrapping.
- HALT:
  - All registers hold; `if_valid` = 0.
  - Redirects and `id_ready` are ignored.
  - Exit is by reset only.
- Reset asserted mid-operation: every register returns to its reset value asynchronously, and any in-flight instruction is discarded.

## Timing
- Fetch latency is 1 cycle: the word at `pc_q` appears on `if_instr` after the next rising edge with `id_ready`=1.
- First cycle after reset release: `imem_addr` = 32'h0100_0000 and `if_valid` = 0. After the first advancing edge, `if_valid` = 1.
- Redirect penalty is exactly one bubble. The edge that takes the redirect produces `if_valid` = 0; the following advancing edge delivers the word at the target.
- Redirect and stall in the same cycle: the redirect wins, the pipeline is flushed, and no instruction is lost that decode had not already accepted.
- `imem_addr` is registered-only (it is `pc_q`), so there is no combinational path from any input to `imem_addr`.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined:
  - On an advancing edge, if `pc_q` < IMEM_BASE or `pc_q` ≥ IMEM_BASE + 4·IMEM_WORDS, the unit enters HALT, sets `fetch_fault` = 1, and keeps `if_valid` = 0.
  - A redirect to an out-of-range aligned target is accepted; the fault fires on the next advancing edge.
- `FETCH_BOUNDS_CHECK_EN` undefined: no range check is performed; misalignment is the only fault source.

## Structure
- Package `fetch_pkg` holds:
  - `RESET_PC_DEFAULT`
  - `NOP_INSTR` = 32'h0000_0013
  - the state enum `fetch_state_t` {RUN, HALT}
- Sub-module `if_id_reg`: the IF/ID pipeline register with load, hold, and flush controls. `fetch_unit` holds the PC, the FSM, and the counter.

## Test plan
- **Reset and sequential fetch.** Stimulus: `imem` preloaded with 00100093, 00200113, 002080b3, ffdff06f; release reset; `id_ready`=1 for 4 edges. Required: `if_instr` shows those four words in order, `if_pc` = 0100_0000, 0100_0004, 0100_0008, 0100_000C, and `fetch_count` = 4.
- **Stall.** Stimulus: hold `id_ready`=0 for 3 cycles after the second fetch. Required: `if_instr` stays 00200113, `imem_addr` stays 0100_0008, and `fetch_count` stays 2.
- **Redirect on jump.** Stimulus: `redirect_valid`=1 with `redirect_pc`=0100_0008 while `id_ready`=0. Required: one bubble (`if_valid`=0), then `if_instr` = 002080b3.
- **Misaligned redirect.** Stimulus: `redirect_pc` = 0100_0006. Required: `fetch_fault`=1, `if_valid` stays 0, and later redirects are ignored until `rst` goes low then high.
- **Wrap-around.** Stimulus: redirect to FFFF_FFFC with `FETCH_BOUNDS_CHECK_EN` undefined. Required: the next `imem_addr` is 0000_0000 and there is no fault.
- **Bounds check.** Stimulus: `FETCH_BOUNDS_CHECK_EN` defined, redirect to 0000_1000, then advance. Required: HALT entered and `fetch_fault`=1.
